// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous fixed-latency memory between the
// CPU port (p0) and a DMA/loader port (p1); one registered command per access.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          last, last_next;
    logic          gnt_valid, gnt_port;

    logic          mem_en_next, mem_we_next;
    logic [AW-1:0] mem_addr_next;
    logic [DW-1:0] mem_wdata_next;
    logic          p0_ack_next, p1_ack_next;
    logic [DW-1:0] p0_rdata_next, p1_rdata_next;
    logic          owner_next, busy_next;

    // On contention the port that did not win last time is served.
    assign gnt_valid = p0_req | p1_req;
    assign gnt_port  = p1_req & (~p0_req | ~last);

    always_ff @(posedge clock) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of the order the processes are evaluated.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: assign a default before the case so no path leaves the
        // variable unassigned, which would infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (gnt_valid) state_next = ISSUE;
            ISSUE:   state_next = mem_we ? DONE : WAIT;
            WAIT:    if (cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_en_next    = 1'b0;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        p0_ack_next    = 1'b0;
        p1_ack_next    = 1'b0;
        p0_rdata_next  = p0_rdata;
        p1_rdata_next  = p1_rdata;
        owner_next     = owner;
        last_next      = last;
        cnt_next       = cnt;
        busy_next      = (state_next != IDLE);
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    mem_en_next    = 1'b1;
                    mem_we_next    = gnt_port ? p1_we    : p0_we;
                    mem_addr_next  = gnt_port ? p1_addr  : p0_addr;
                    mem_wdata_next = gnt_port ? p1_wdata : p0_wdata;
                    owner_next     = gnt_port;
                    last_next      = gnt_port;
                end
            end
            ISSUE: begin
                if (mem_we) begin
                    p0_ack_next = ~owner;
                    p1_ack_next = owner;
                end else begin
                    cnt_next = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CW'(1);
                end else begin
                    // Only the owner's read register is updated.
                    p0_ack_next = ~owner;
                    p1_ack_next = owner;
                    if (owner) p1_rdata_next = mem_rdata;
                    else       p0_rdata_next = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            owner     <= 1'b0;
            busy      <= 1'b0;
            last      <= 1'b1;
            cnt       <= '0;
        end else begin
            mem_en    <= mem_en_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            p0_ack    <= p0_ack_next;
            p1_ack    <= p1_ack_next;
            p0_rdata  <= p0_rdata_next;
            p1_rdata  <= p1_rdata_next;
            owner     <= owner_next;
            busy      <= busy_next;
            last      <= last_next;
            cnt       <= cnt_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random two-master traffic,
// every cycle compared against a transaction-level timing model.
module tb_mem_arbiter;

    localparam int LAT = 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        req [2];
    logic        we [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        p0_ack, p1_ack, mem_en, mem_we, busy, owner;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  ack_v;
    assign ack_v = {p1_ack, p0_ack};

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
        .clock(clock), .reset(reset),
        .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    // Second instance with a 3-cycle memory for the latency scenario.
    logic        q_req, q_we_i, q_ack, q1_ack, q_en, q_we, q_busy, q_owner;
    logic [31:0] q_addr_i, q_wdata_i, q_rdata, q1_rdata, q_addr, q_wdata, q_mrdata;
    logic [31:0] q_pipe [3];
    assign q_mrdata = q_pipe[2];

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_dut3 (
        .clock(clock), .reset(reset),
        .p0_req(q_req), .p0_we(q_we_i), .p0_addr(q_addr_i), .p0_wdata(q_wdata_i),
        .p0_ack(q_ack), .p0_rdata(q_rdata),
        .p1_req(1'b0), .p1_we(1'b0), .p1_addr(32'h0), .p1_wdata(32'h0),
        .p1_ack(q1_ack), .p1_rdata(q1_rdata),
        .mem_en(q_en), .mem_we(q_we), .mem_addr(q_addr), .mem_wdata(q_wdata),
        .mem_rdata(q_mrdata), .busy(q_busy), .owner(q_owner)
    );

    // Synchronous memories; outside the valid read slot they return noise.
    logic [31:0] mem [256];
    logic [31:0] shadow [256];
    logic [31:0] rpipe;
    assign mem_rdata = rpipe;

    always @(posedge clock) begin
        if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        rpipe <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : $urandom;
        q_pipe[0] <= (q_en && !q_we) ? (32'hCAFE_0000 | q_addr) : $urandom;
        q_pipe[1] <= q_pipe[0];
        q_pipe[2] <= q_pipe[1];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model: one outstanding transaction described by its grant
    // cycle and completion cycle, derived from the documented timing.
    bit          chk_en = 0;
    bit          m_act = 0, m_port, m_we, m_last, m_owner, issue, idle_now;
    int          m_gc, m_done, w;
    logic [31:0] m_addr, m_wdata, m_rdval;
    logic [31:0] m_rdata [2];
    bit          ack_q [2];
    bit          gnt_q [2];

    always @(negedge clock) begin
        if (chk_en) begin
            if (m_act && cyc == m_done && !m_we) m_rdata[m_port] = m_rdval;
            issue = m_act && (cyc == m_gc + 1);
            check("mem_en",    mem_en,    issue);
            check("mem_we",    mem_we,    issue && m_we);
            check("mem_addr",  mem_addr,  m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
            check("busy",      busy,      m_act && cyc >= m_gc + 1);
            check("owner",     owner,     m_owner);
            check("p0_ack",    p0_ack,    m_act && cyc == m_done && m_port == 1'b0);
            check("p1_ack",    p1_ack,    m_act && cyc == m_done && m_port == 1'b1);
            check("p0_rdata",  p0_rdata,  m_rdata[0]);
            check("p1_rdata",  p1_rdata,  m_rdata[1]);
        end
        ack_q[0] = p0_ack;
        ack_q[1] = p1_ack;
        gnt_q[0] = mem_en && !owner;
        gnt_q[1] = mem_en && owner;
        idle_now = !m_act;
        if (m_act && cyc == m_done) m_act = 0;
        if (reset) begin
            m_act = 0; m_last = 1; m_owner = 0; m_addr = 0; m_wdata = 0;
            m_rdata[0] = 0; m_rdata[1] = 0;
            chk_en = 1;
        end else if (idle_now && (req[0] || req[1])) begin
            w       = (req[0] && req[1]) ? int'(!m_last) : int'(req[1]);
            m_act   = 1;
            m_gc    = cyc;
            m_port  = w[0];
            m_last  = w[0];
            m_owner = w[0];
            m_we    = we[w];
            m_addr  = addr[w];
            m_wdata = wdata[w];
            m_rdval = shadow[addr[w][7:0]];
            if (m_we) shadow[addr[w][7:0]] = wdata[w];
            m_done  = cyc + 2 + (m_we ? 0 : LAT);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_neg(input int c);
        do @(negedge clock); while (cyc < c);
    endtask

    task automatic drive(input int p, input bit r, input bit wr, input logic [31:0] a,
                         input logic [31:0] d);
        req[p] = r; we[p] = wr; addr[p] = a; wdata[p] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Raise a request now and return at the negedge of its ack cycle.
    task automatic do_op(input int p, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, output int lat);
        int t0;
        drive(p, 1'b1, wr, a, d);
        t0  = cyc;
        lat = -1;
        for (int k = 0; k < 30 && lat < 0; k++) begin
            @(negedge clock);
            if (ack_v[p]) lat = cyc - t0;
        end
        if (lat < 0) check("ack_wait", ack_v[p], 1);
    endtask

    int order_q [$];
    task automatic collect(input int n);
        order_q.delete();
        for (int k = 0; k < 20 * n && order_q.size() < n; k++) begin
            @(negedge clock);
            if (p0_ack) begin order_q.push_back(0); check("owner_at_ack0", owner, 0); end
            if (p1_ack) begin order_q.push_back(1); check("owner_at_ack1", owner, 1); end
        end
        check("ack_count", order_q.size(), n);
    endtask

    bit pend [2];
    bit fickle [2];

    task automatic new_op(input int p);
        req[p] = 1'b1; pend[p] = 1'b1;
        we[p] = 1'($urandom_range(1, 0));
        addr[p] = $urandom_range(63, 0);
        wdata[p] = $urandom;
        fickle[p] = ($urandom_range(3, 0) == 0);
    endtask

    task automatic rand_step(input bit allow_new);
        for (int p = 0; p < 2; p++) begin
            if (pend[p] && ack_q[p]) begin
                pend[p] = 1'b0;
                if (allow_new && $urandom_range(1, 0) == 1) new_op(p);
                else req[p] = 1'b0;
            end else if (pend[p] && fickle[p] && gnt_q[p]) begin
                req[p] = 1'b0; addr[p] = $urandom; wdata[p] = $urandom;
                we[p] = 1'($urandom_range(1, 0));
            end else if (!pend[p] && allow_new && $urandom_range(2, 0) == 0) begin
                new_op(p);
            end else if (!pend[p]) begin
                req[p] = 1'b0;
            end
        end
    endtask

    initial begin
        int t, lat, acks;
        int en_cnt, busy_cnt, ack_t;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, lat, acks, en_cnt, busy_cnt, ack_t;
        reset = 1'b1;
        for (int p = 0; p < 2; p++) begin
            drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
            pend[p] = 1'b0; fickle[p] = 1'b0;
        end
        q_req = 1'b0; q_we_i = 1'b0; q_addr_i = 32'h0; q_wdata_i = 32'h0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            shadow[i] = mem[i];
        end
        mem[16] = 32'hDEAD_BEEF;
        shadow[16] = 32'hDEAD_BEEF;

        // Single p0 read, latency 1.
        do_reset();
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        t = cyc;
        wait_neg(t + 1);
        check("t1_mem_en", mem_en, 1);
        check("t1_mem_addr", mem_addr, 32'h10);
        wait_neg(t + 3);
        check("t1_ack", p0_ack, 1);
        check("t1_rdata", p0_rdata, 32'hDEAD_BEEF);
        tick();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_neg(t + 4);
        check("t1_busy", busy, 0);

        // p1 write then read back.
        do_reset();
        do_op(1, 1'b1, 32'h20, 32'h1234_5678, lat);
        check("t2_wr_lat", lat, 2);
        tick();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        do_op(1, 1'b0, 32'h20, 32'h0, lat);
        check("t2_rd_lat", lat, 3);
        check("t2_p1_rdata", p1_rdata, 32'h1234_5678);
        check("t2_p0_rdata", p0_rdata, 32'h0);
        tick();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Both ports saturating from reset: strict alternation starting at p0.
        do_reset();
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h20, 32'h0);
        collect(4);
        for (int i = 0; i < 4; i++)
            check("t3_order", (i < order_q.size()) ? order_q[i] : 9, i % 2);
        tick();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Latency-3 instance: single read.
        tick();
        q_req = 1'b1; q_addr_i = 32'h30;
        t = cyc; en_cnt = 0; busy_cnt = 0; ack_t = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (q_en) en_cnt++;
            if (q_busy) busy_cnt++;
            if (q_ack && ack_t < 0) begin
                ack_t = cyc;
                check("t4_rdata", q_rdata, 32'hCAFE_0030);
            end
        end
        check("t4_ack_lat", ack_t - t, 5);
        check("t4_en_cycles", en_cnt, 1);
        check("t4_busy_cycles", busy_cnt, 5);
        tick();
        q_req = 1'b0;

        // Request dropped and address changed right after the grant.
        tick();
        drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
        tick();
        drive(0, 1'b0, 1'b0, 32'h44, 32'h0);
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (p0_ack) begin
                acks++;
                check("t5_mem_addr", mem_addr, 32'h40);
            end
        end
        check("t5_acks", acks, 1);

        // Reset during WAIT aborts the read; p0 wins the next contention.
        do_reset();
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        t = cyc;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h20, 32'h0);
        wait_neg(t + 3);
        check("t6_busy", busy, 0);
        check("t6_ack", p0_ack, 0);
        check("t6_mem_en", mem_en, 0);
        check("t6_owner", owner, 0);
        check("t6_rdata", p0_rdata, 32'h0);
        check("t6_mem_addr", mem_addr, 32'h0);
        wait_neg(t + 4);
        check("t6_first_owner", owner, 0);
        collect(2);
        check("t6_first_port", (order_q.size() > 0) ? order_q[0] : 9, 0);
        tick();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Random two-master traffic, then let outstanding accesses finish.
        for (int i = 0; i < 1500; i++) begin
            tick();
            rand_step(1'b1);
        end
        for (int i = 0; i < 60 && (pend[0] || pend[1]); i++) begin
            tick();
            rand_step(1'b0);
        end
        check("drain_pending", {30'h0, pend[1], pend[0]}, 32'h0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
